// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: converts five BCD digits into a 14-bit binary value
// with reverse double dabble, one shift step per clock, behind a
// start/busy/done handshake. Results above 16383 saturate and flag overflow;
// any digit above 9 aborts the conversion and flags error.
module bcd_to_binary_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  tenThousands,
    input  logic [3:0]  Thousands,
    input  logic [3:0]  Hundreds,
    input  logic [3:0]  Tens,
    input  logic [3:0]  Ones,
    output logic [13:0] binary,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

    localparam int NUM_DIGITS = 5;
    localparam int ACC_W      = 17;
    localparam int REG_W      = ACC_W + 4 * NUM_DIGITS;

    state_t             state_reg;
    state_t             state_next;

    // {bcd digits, accumulator}; bits shift from the digits into the accumulator
    logic [REG_W-1:0]   r_reg;
    logic [4:0]         count_reg;
    logic               invalid_reg;

    logic [13:0]        binary_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               overflow_reg;
    logic               error_reg;

    logic [3:0]         digit_in [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_bad;
    logic               digits_bad;

    logic [REG_W-1:0]   shifted;
    logic [REG_W-1:0]   stepped;
    logic [ACC_W-1:0]   acc;

    assign digit_in[0] = Ones;
    assign digit_in[1] = Tens;
    assign digit_in[2] = Hundreds;
    assign digit_in[3] = Thousands;
    assign digit_in[4] = tenThousands;

    // One reverse double dabble step: shift right, then correct each digit
    // that picked up a half-weight bit (>= 8) by subtracting 3.
    assign shifted = {1'b0, r_reg[REG_W-1:1]};
    assign stepped[ACC_W-1:0] = shifted[ACC_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = shifted[ACC_W + 4*gi +: 4];
            assign stepped[ACC_W + 4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
            assign digit_bad[gi] = (digit_in[gi] > 4'd9);
        end
    endgenerate

    assign digits_bad = |digit_bad;
    assign acc        = r_reg[ACC_W-1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an invalid capture is rejected on its first CONVERT
    // cycle without shifting, so the error result lands one cycle later than
    // the capture and busy never rises for it.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (invalid_reg || (count_reg == 5'd16)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture, shift steps, and result/flag update in FINISH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg        <= '0;
            count_reg    <= '0;
            invalid_reg  <= 1'b0;
            binary_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            done_reg <= (state_reg == FINISH);
            busy_reg <= (state_reg == CONVERT) && !invalid_reg;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        r_reg       <= {tenThousands, Thousands, Hundreds, Tens, Ones,
                                        {ACC_W{1'b0}}};
                        count_reg   <= '0;
                        invalid_reg <= digits_bad;
                    end
                end
                CONVERT: begin
                    if (!invalid_reg) begin
                        r_reg     <= stepped;
                        count_reg <= count_reg + 5'd1;
                    end
                end
                FINISH: begin
                    if (invalid_reg) begin
                        binary_reg   <= '0;
                        overflow_reg <= 1'b0;
                        error_reg    <= 1'b1;
                    end else if (acc > 17'd16383) begin
                        binary_reg   <= 14'h3FFF;
                        overflow_reg <= 1'b1;
                        error_reg    <= 1'b0;
                    end else begin
                        binary_reg   <= acc[13:0];
                        overflow_reg <= 1'b0;
                        error_reg    <= 1'b0;
                    end
                end
                default: begin
                    r_reg <= r_reg;
                end
            endcase
        end
    end

    assign binary   = binary_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign error    = error_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed bench for the sequential BCD-to-binary
// converter; expected results are queued at start and checked at done.
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  d4, d3, d2, d1, d0;
    logic [13:0] binary;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [13:0] bin;
        logic        ov;
        logic        err;
    } exp_t;

    exp_t sb[$];

    bcd_to_binary_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tenThousands (d4),
        .Thousands    (d3),
        .Hundreds     (d2),
        .Tens         (d1),
        .Ones         (d0),
        .binary       (binary),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .error        (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal value of the digits, saturated at 16383
    function automatic exp_t model(input int a4, a3, a2, a1, a0);
        exp_t e;
        int   v;
        if (a4 > 9 || a3 > 9 || a2 > 9 || a1 > 9 || a0 > 9) begin
            e.bin = 14'd0;
            e.ov  = 1'b0;
            e.err = 1'b1;
        end else begin
            v = a4 * 10000 + a3 * 1000 + a2 * 100 + a1 * 10 + a0;
            e.err = 1'b0;
            if (v > 16383) begin
                e.bin = 14'h3FFF;
                e.ov  = 1'b1;
            end else begin
                e.bin = v[13:0];
                e.ov  = 1'b0;
            end
        end
        return e;
    endfunction

    // Drive digits and a one-cycle start; the edge consumed here is T
    task automatic start_conv(input int a4, a3, a2, a1, a0);
        d4 = a4[3:0];
        d3 = a3[3:0];
        d2 = a2[3:0];
        d1 = a1[3:0];
        d0 = a0[3:0];
        start = 1'b1;
        sb.push_back(model(a4, a3, a2, a1, a0));
        tick();
        start = 1'b0;
        $display("start digits=%0d,%0d,%0d,%0d,%0d", a4, a3, a2, a1, a0);
    endtask

    // Wait for done, checking latency from T, busy cycles and the result.
    // With disturb set, digits change after T+3 and start is re-pulsed at T+5.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                             input bit disturb);
        int   n;
        int   busy_cnt;
        exp_t e;
        n        = 0;
        busy_cnt = 0;
        while (n < 40) begin
            tick();
            n++;
            if (busy === 1'b1) busy_cnt++;
            if (disturb && n == 3) begin
                d4 = 4'd9; d3 = 4'd8; d2 = 4'd7; d1 = 4'd6; d0 = 4'd5;
            end
            if (disturb && n == 4) start = 1'b1;
            if (disturb && n == 5) start = 1'b0;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout observed=no_done expected=done_within_40", tag);
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_binary"}, {18'd0, binary}, {18'd0, e.bin});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.ov});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e.err});
        $display("done %s binary=%0d overflow=%0b error=%0b latency=%0d", tag, binary,
                 overflow, error, n);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dcount;
        reset = 1'b1;
        start = 1'b0;
        d4 = 0; d3 = 0; d2 = 0; d1 = 0; d0 = 0;
        tick();
        tick();
        chk("reset_binary", {18'd0, binary}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: zero
        start_conv(0, 0, 0, 0, 0);
        wait_done("zero", 18, 17, 1'b0);

        // 2: ordinary value and the largest non-saturating value
        start_conv(1, 2, 3, 4, 5);
        wait_done("v12345", 18, 17, 1'b0);
        start_conv(1, 6, 3, 8, 3);
        wait_done("v16383", 18, 17, 1'b0);

        // 3: saturation
        start_conv(1, 6, 3, 8, 4);
        wait_done("v16384", 18, 17, 1'b0);
        start_conv(9, 9, 9, 9, 9);
        wait_done("v99999", 18, 17, 1'b0);

        // 4: invalid digit, then recovery
        start_conv(0, 0, 10, 0, 0);
        wait_done("bad_digit", 2, 0, 1'b0);
        start_conv(0, 0, 0, 0, 7);
        wait_done("v7", 18, 17, 1'b0);

        // 5: digits changed and start re-pulsed during conversion
        start_conv(0, 2, 0, 2, 4);
        wait_done("ignore_start", 18, 17, 1'b1);

        // 6: reset in the middle of a conversion
        start_conv(0, 9, 8, 7, 6);
        for (int i = 0; i < 8; i++) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_binary", {18'd0, binary}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        void'(sb.pop_front());
        tick();
        tick();
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        chk("midreset_no_done", dcount, 0);
        $display("reset mid-conversion done_pulses=%0d", dcount);
        start_conv(0, 0, 0, 4, 2);
        wait_done("v42", 18, 17, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
